// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
//   arb_state_e    : arbiter FSM states (idle, owned, one-cycle turnaround)
//   DefaultMaxHold : default hold limit used when the timeout feature is built
//   id_width()     : width of the owner index for a given requester count
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultMaxHold = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
// Scans req_i starting at ptr_i, wrapping modulo N, and reports the first hit.
//   req_i    : request vector
//   ptr_i    : index with highest priority this round (must be < N)
//   valid_o  : any request present
//   idx_o    : index of the winner (0 when none)
//   onehot_o : one-hot of the winner (0 when none)
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic           valid_o,
  output logic [IdW-1:0] idx_o,
  output logic [N-1:0]   onehot_o
);

  logic [N-1:0] rot;
  logic [IdW:0] sum;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    sum      = '0;
    // rot[j] is the request at position (ptr + j) mod N
    rot      = N'({req_i, req_i} >> ptr_i);
    for (int unsigned j = 0; j < N; j++) begin
      if (!valid_o && rot[j]) begin
        valid_o = 1'b1;
        sum     = {1'b0, ptr_i} + (IdW+1)'(j);
        if (sum >= (IdW+1)'(N)) begin
          sum = sum - (IdW+1)'(N);
        end
        idx_o = sum[IdW-1:0];
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      onehot_o[k] = valid_o && (idx_o == IdW'(k));
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter sharing one resource among N requesters.
// An owner keeps the grant until it strobes DONE or drops REQ; every handover
// passes through one dead RELEASE cycle, and the departing owner becomes the
// lowest priority for the next round.
// Optional hold limit: define ARB_TIMEOUT_EN to build the MAX_HOLD counter.
// Without it, TIMEOUT is constant 0 and an owner may hold indefinitely.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   REQ     : per-requester level request
//   DONE    : owner's single-cycle release strobe (ignored for non-owners)
//   GNT     : registered one-hot grant, zero when no owner
//   GNT_ID  : index of the current owner, zero when no owner
//   BUSY    : high while GNT is non-zero
//   TIMEOUT : one-cycle pulse during a RELEASE forced by the hold limit
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           REQ,
  input  logic [N-1:0]           DONE,
  output logic [N-1:0]           GNT,
  output logic [id_width(N)-1:0] GNT_ID,
  output logic                   BUSY,
  output logic                   TIMEOUT
);

  localparam int unsigned IdW = id_width(N);

  if (N < 2 || N > 16 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_grant_arbiter: N must be 2..16 and MAX_HOLD must be >= 2");
  end

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IdW-1:0] gnt_id_q, gnt_id_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic           timeout_q, timeout_d;

  logic           pick_valid;
  logic [IdW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic           owner_rel;
  logic           expire;
  logic [IdW-1:0] ptr_after_owner;

  rr_pick #(
    .N   (N),
    .IdW (IdW)
  ) u_pick (
    .req_i    (REQ),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  assign owner_rel       = DONE[gnt_id_q] | ~REQ[gnt_id_q];
  assign ptr_after_owner = (gnt_id_q == IdW'(N - 1)) ? '0 : gnt_id_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD);

  logic [HoldW-1:0] hold_q, hold_d;

  // hold_q is 0 in the first GRANT cycle, so MAX_HOLD-1 marks the last allowed one
  assign expire = (state_q == GRANT) && (hold_q == HoldW'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if (state_q == GRANT) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE, RELEASE: begin
        if (pick_valid) begin
          state_d  = GRANT;
          gnt_d    = pick_onehot;
          gnt_id_d = pick_idx;
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      GRANT: begin
        if (owner_rel || expire) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          ptr_d     = ptr_after_owner;
          // a real release on the expiry cycle wins over the timeout
          timeout_d = expire & ~owner_rel;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_ID  = gnt_id_q;
  assign BUSY    = |gnt_q;
  assign TIMEOUT = timeout_q;

endmodule
